// File: rtl/serial_mag_comparator_if.sv
`default_nettype none
// ============================================================================
// Module   : serial_mag_comparator_if
// Brief    : Operand/result handshake bundle for serial_mag_comparator.
// Revision : 1.0
// ============================================================================
interface serial_mag_comparator_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] x_in;
    logic [WIDTH-1:0] y_in;
    logic             out_valid;
    logic             out_ready;
    logic             xgty;
    logic             xlty;
    logic             xeqy;

    modport master (
        output in_valid, x_in, y_in, out_ready,
        input  in_ready, out_valid, xgty, xlty, xeqy
    );

    modport slave (
        input  in_valid, x_in, y_in, out_ready,
        output in_ready, out_valid, xgty, xlty, xeqy
    );
endinterface
`default_nettype wire

// File: rtl/serial_mag_comparator.sv
`default_nettype none
// ============================================================================
// Module   : serial_mag_comparator
// Brief    : Unsigned magnitude comparator, 2 bits per cycle MSB first, with early exit.
// Revision : 1.0
// ============================================================================
module serial_mag_comparator #(
    parameter int WIDTH = 8
) (
    input  wire                     clk,
    input  wire                     rst_n,
    serial_mag_comparator_if.slave  bus
);

    localparam int CNT_W = $clog2(WIDTH / 2 + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPARE = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   x_sh_q, x_sh_d;
    logic [WIDTH-1:0]   y_sh_q, y_sh_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               gt_q, gt_d;
    logic               lt_q, lt_d;
    logic               eq_q, eq_d;

    logic [1:0]         w_x_slice;
    logic [1:0]         w_y_slice;

    assign w_x_slice = x_sh_q[WIDTH-1 -: 2];
    assign w_y_slice = y_sh_q[WIDTH-1 -: 2];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            x_sh_q  <= '0;
            y_sh_q  <= '0;
            cnt_q   <= '0;
            gt_q    <= 1'b0;
            lt_q    <= 1'b0;
            eq_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            x_sh_q  <= x_sh_d;
            y_sh_q  <= y_sh_d;
            cnt_q   <= cnt_d;
            gt_q    <= gt_d;
            lt_q    <= lt_d;
            eq_q    <= eq_d;
        end
    end

    always_comb begin
        state_d = state_q;
        x_sh_d  = x_sh_q;
        y_sh_d  = y_sh_q;
        cnt_d   = cnt_q;
        gt_d    = gt_q;
        lt_d    = lt_q;
        eq_d    = eq_q;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    x_sh_d  = bus.x_in;
                    y_sh_d  = bus.y_in;
                    cnt_d   = CNT_W'(WIDTH / 2);
                    gt_d    = 1'b0;
                    lt_d    = 1'b0;
                    eq_d    = 1'b0;
                    state_d = COMPARE;
                end
            end
            COMPARE: begin
                // First unequal slice decides; equal slices fall through to the next pair.
                if (w_x_slice > w_y_slice) begin
                    gt_d    = 1'b1;
                    state_d = DONE;
                end else if (w_x_slice < w_y_slice) begin
                    lt_d    = 1'b1;
                    state_d = DONE;
                end else if (cnt_q == CNT_W'(1)) begin
                    eq_d    = 1'b1;
                    state_d = DONE;
                end else begin
                    x_sh_d  = x_sh_q << 2;
                    y_sh_d  = y_sh_q << 2;
                    cnt_d   = cnt_q - CNT_W'(1);
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.xgty      = gt_q;
    assign bus.xlty      = lt_q;
    assign bus.xeqy      = eq_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_mag_comparator.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_mag_comparator
// Brief    : Directed self-checking bench for serial_mag_comparator (WIDTH=8).
// Revision : 1.0
// ============================================================================
module tb_serial_mag_comparator;

    localparam int WIDTH = 8;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    serial_mag_comparator_if #(.WIDTH(WIDTH)) bus ();

    serial_mag_comparator #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present a pair at a falling edge; returns at the falling edge after the accept edge
    // with the operand inputs scrambled so any late sampling would corrupt the result.
    task automatic do_accept(input logic [7:0] x, input logic [7:0] y);
        bus.in_valid = 1'b1;
        bus.x_in     = x;
        bus.y_in     = y;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.x_in     = ~x;
        bus.y_in     = ~y;
    endtask

    // Edges after the accept edge until out_valid is seen; -1 if the budget expires.
    task automatic wait_done(output int lat);
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic release_result();
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", bus.in_ready); end
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid); end
        total++; if ({bus.xgty, bus.xlty, bus.xeqy} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b want=000", {bus.xgty, bus.xlty, bus.xeqy}); end
    endtask

    task automatic test_gt_first_slice();
        int lat;
        do_accept(8'hC3, 8'h43);
        wait_done(lat);
        total++; if (lat !== 1) begin bad++; $display("FAIL gt_latency got=%0d want=1", lat); end
        total++; if ({bus.xgty, bus.xlty, bus.xeqy} !== 3'b100) begin bad++; $display("FAIL gt_flags got=%b want=100", {bus.xgty, bus.xlty, bus.xeqy}); end
        release_result();
        total++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin bad++; $display("FAIL gt_release got ov=%b ir=%b want ov=0 ir=1", bus.out_valid, bus.in_ready); end
        total++; if (bus.xgty !== 1'b1) begin bad++; $display("FAIL gt_retained got=%b want=1", bus.xgty); end
    endtask

    task automatic test_lt_last_slice();
        int lat;
        do_accept(8'h5A, 8'h5B);
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL lt_busy_in_ready got=%b want=0", bus.in_ready); end
        wait_done(lat);
        total++; if (lat !== 4) begin bad++; $display("FAIL lt_latency got=%0d want=4", lat); end
        total++; if ({bus.xgty, bus.xlty, bus.xeqy} !== 3'b010) begin bad++; $display("FAIL lt_flags got=%b want=010", {bus.xgty, bus.xlty, bus.xeqy}); end
        release_result();
    endtask

    task automatic test_equal();
        int lat;
        do_accept(8'hA5, 8'hA5);
        wait_done(lat);
        total++; if (lat !== 4) begin bad++; $display("FAIL eq_latency got=%0d want=4", lat); end
        total++; if ({bus.xgty, bus.xlty, bus.xeqy} !== 3'b001) begin bad++; $display("FAIL eq_flags got=%b want=001", {bus.xgty, bus.xlty, bus.xeqy}); end
        release_result();
    endtask

    task automatic test_backpressure();
        int lat;
        do_accept(8'hF0, 8'h0F);
        wait_done(lat);
        total++; if (lat !== 1) begin bad++; $display("FAIL bp_latency got=%0d want=1", lat); end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            total++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || {bus.xgty, bus.xlty, bus.xeqy} !== 3'b100) begin
                bad++;
                $display("FAIL bp_hold cycle=%0d got ov=%b ir=%b flags=%b want ov=1 ir=0 flags=100",
                         c, bus.out_valid, bus.in_ready, {bus.xgty, bus.xlty, bus.xeqy});
            end
        end
        release_result();
        total++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin bad++; $display("FAIL bp_release got ov=%b ir=%b want ov=0 ir=1", bus.out_valid, bus.in_ready); end
    endtask

    task automatic test_ignore_inputs();
        do_accept(8'h00, 8'hFF);
        bus.in_valid = 1'b1;
        bus.x_in     = 8'hFF;
        bus.y_in     = 8'h00;
        @(negedge clk);
        bus.in_valid = 1'b0;
        total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL ign_out_valid got=%b want=1", bus.out_valid); end
        total++; if ({bus.xgty, bus.xlty, bus.xeqy} !== 3'b010) begin bad++; $display("FAIL ign_flags got=%b want=010", {bus.xgty, bus.xlty, bus.xeqy}); end
        release_result();
    endtask

    task automatic test_reset_mid_compare();
        int lat;
        int seen;
        do_accept(8'h5A, 8'h5B);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        total++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || {bus.xgty, bus.xlty, bus.xeqy} !== 3'b000) begin
            bad++;
            $display("FAIL midrst_state got ir=%b ov=%b flags=%b want ir=1 ov=0 flags=000",
                     bus.in_ready, bus.out_valid, {bus.xgty, bus.xlty, bus.xeqy});
        end
        seen = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b0) seen++;
        end
        total++; if (seen !== 0) begin bad++; $display("FAIL midrst_no_pulse got=%0d want=0", seen); end
        do_accept(8'h01, 8'h00);
        wait_done(lat);
        total++; if (lat !== 4) begin bad++; $display("FAIL midrst_latency got=%0d want=4", lat); end
        total++; if ({bus.xgty, bus.xlty, bus.xeqy} !== 3'b100) begin bad++; $display("FAIL midrst_flags got=%b want=100", {bus.xgty, bus.xlty, bus.xeqy}); end
        release_result();
    endtask

    task automatic test_back_to_back();
        logic [7:0] xs [6];
        logic [7:0] ys [6];
        logic [2:0] fl [6];
        int         lt [6];
        int         lat;
        xs = '{8'h80, 8'h12, 8'h34, 8'h6C, 8'hFF, 8'h00};
        ys = '{8'h7F, 8'h13, 8'h24, 8'h7C, 8'hFF, 8'h00};
        fl = '{3'b100, 3'b010, 3'b100, 3'b010, 3'b001, 3'b001};
        lt = '{1, 4, 2, 2, 4, 4};
        for (int i = 0; i < 6; i++) begin
            total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready[%0d] got=%b want=1", i, bus.in_ready); end
            do_accept(xs[i], ys[i]);
            wait_done(lat);
            total++; if (lat !== lt[i]) begin bad++; $display("FAIL b2b_latency[%0d] got=%0d want=%0d", i, lat, lt[i]); end
            total++;
            if ({bus.xgty, bus.xlty, bus.xeqy} !== fl[i]) begin
                bad++;
                $display("FAIL b2b_flags[%0d] got=%b want=%b", i, {bus.xgty, bus.xlty, bus.xeqy}, fl[i]);
            end
            release_result();
        end
    endtask

    initial begin
        total         = 0;
        bad           = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.x_in      = '0;
        bus.y_in      = '0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_gt_first_slice();
        test_lt_last_slice();
        test_equal();
        test_backpressure();
        test_ignore_inputs();
        test_reset_mid_compare();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
